// File: rtl/vram_fetch_arbiter.sv
// Shares one single-port frame memory between the line prefetch (ping-pong line
// buffer fill) and host writes; the host takes the cycles the fetch leaves free.
module vram_fetch_arbiter #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned V_ACTIVE = 800,
  parameter int unsigned V_TOTAL  = 828,
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned BURST    = 4
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic [14:0]       hpos,
  input  logic [14:0]       vpos,
  input  logic              host_valid,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [15:0]       host_data,
  output logic              host_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              lb_we,
  output logic              lb_bank,
  output logic [10:0]       lb_addr,
  output logic [15:0]       lb_wdata,
  output logic              scan_bank,
  output logic              underrun,
  input  logic              underrun_clr
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int unsigned CNT_W = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(BURST);
  localparam logic [15:0]       V_ACTIVE_L = 16'(V_ACTIVE);
  localparam logic [14:0]       V_LAST     = 15'(V_TOTAL - 1);
  localparam logic [10:0]       WORD_LAST  = 11'(H_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] H_STEP     = ADDR_W'(H_ACTIVE);

  logic [1:0]        state_q, state_d;
  logic [10:0]       word_q, word_d;
  logic              bank_q, bank_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              underrun_q;

  logic              mem_rd_q, mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [15:0]       mem_wdata_q;
  logic [10:0]       rd_idx_q;
  logic              rd_bank_q;

  logic [RD_LAT-1:0]       ret_v_q, ret_bank_q;
  logic [RD_LAT-1:0][10:0] ret_idx_q;

  logic        line_start, target_zero, has_target, target_bank;
  logic [15:0] vpos_inc;
  logic        fetching, host_wins, grant_fetch, grant_host, pending;

  assign line_start  = (hpos == 15'd0);
  assign vpos_inc    = {1'b0, vpos} + 16'd1;
  assign target_zero = (vpos == V_LAST);
  assign has_target  = (vpos_inc < V_ACTIVE_L) || target_zero;
  assign target_bank = target_zero ? 1'b0 : vpos_inc[0];

  assign fetching    = (state_q == FETCH);
  assign host_wins   = host_valid && (cnt_q >= CNT_MAX);
  assign grant_fetch = fetching && !host_wins;
  assign grant_host  = host_valid && (!fetching || host_wins);
  assign host_ready  = grant_host;

  // A read in the final return stage retires this cycle, so it no longer holds DRAIN.
  always_comb begin
    pending = mem_rd_q;
    for (int i = 0; i < int'(RD_LAT) - 1; i++) pending = pending | ret_v_q[i];
  end

  always_comb begin
    cnt_d = cnt_q;
    if (grant_host || !host_valid) cnt_d = '0;
    else if (grant_fetch && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bank_d  = bank_q;
    base_d  = base_q;
    case (state_q)
      FETCH: begin
        if (grant_fetch) begin
          word_d = word_q + 11'd1;
          if (word_q == WORD_LAST) state_d = DRAIN;
        end
      end
      DRAIN:   if (!pending) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A line start overrides everything: late fetches are abandoned, not finished.
    if (line_start) begin
      if (has_target) begin
        state_d = FETCH;
        word_d  = 11'd0;
        bank_d  = target_bank;
        base_d  = target_zero ? '0 : base_q + H_STEP;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      word_q     <= '0;
      bank_q     <= 1'b0;
      base_q     <= '0;
      cnt_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      bank_q  <= bank_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      if (line_start && (state_q != IDLE)) underrun_q <= 1'b1;
      else if (underrun_clr)               underrun_q <= 1'b0;
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_idx_q    <= '0;
      rd_bank_q   <= 1'b0;
    end else begin
      mem_rd_q <= grant_fetch;
      mem_wr_q <= grant_host;
      if (grant_fetch) begin
        mem_addr_q <= base_q + ADDR_W'(word_q);
        rd_idx_q   <= word_q;
        rd_bank_q  <= bank_q;
      end else if (grant_host) begin
        mem_addr_q  <= host_addr;
        mem_wdata_q <= host_data;
      end
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      ret_v_q    <= '0;
      ret_bank_q <= '0;
      ret_idx_q  <= '0;
    end else begin
      ret_v_q[0]    <= mem_rd_q;
      ret_bank_q[0] <= rd_bank_q;
      ret_idx_q[0]  <= rd_idx_q;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        ret_v_q[i]    <= ret_v_q[i-1];
        ret_bank_q[i] <= ret_bank_q[i-1];
        ret_idx_q[i]  <= ret_idx_q[i-1];
      end
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign lb_we     = ret_v_q[RD_LAT-1];
  assign lb_bank   = ret_bank_q[RD_LAT-1];
  assign lb_addr   = ret_idx_q[RD_LAT-1];
  assign lb_wdata  = lb_we ? mem_rdata : 16'd0;
  assign scan_bank = vpos[0];
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_vram_fetch_arbiter.sv
// Randomized bench for vram_fetch_arbiter: a transaction-level model predicts every
// memory grant, line-buffer write and the underrun flag cycle by cycle.
module tb_vram_fetch_arbiter;

  localparam int H_ACTIVE = 8;
  localparam int V_ACTIVE = 4;
  localparam int V_TOTAL  = 6;
  localparam int ADDR_W   = 20;
  localparam int RD_LAT   = 2;
  localparam int BURST    = 4;
  localparam int AMASK    = (1 << ADDR_W) - 1;

  logic              pixel_clk = 1'b0;
  logic              reset = 1'b1;
  logic [14:0]       hpos = '0, vpos = '0;
  logic              host_valid = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [15:0]       host_data = '0;
  logic              host_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd, mem_wr;
  logic [15:0]       mem_wdata, mem_rdata;
  logic              lb_we, lb_bank;
  logic [10:0]       lb_addr;
  logic [15:0]       lb_wdata;
  logic              scan_bank, underrun;
  logic              underrun_clr = 1'b0;

  vram_fetch_arbiter #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL),
    .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .BURST(BURST)
  ) dut (
    .pixel_clk(pixel_clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .host_valid(host_valid), .host_addr(host_addr), .host_data(host_data),
    .host_ready(host_ready), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_bank(lb_bank),
    .lb_addr(lb_addr), .lb_wdata(lb_wdata), .scan_bank(scan_bank), .underrun(underrun),
    .underrun_clr(underrun_clr)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Memory: read data equals the low 16 bits of the address, RD_LAT cycles after mem_rd.
  logic [15:0] rd_pipe [RD_LAT];
  always @(posedge pixel_clk) begin
    rd_pipe[0] <= mem_rd ? mem_addr[15:0] : 16'hdead;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model state
  typedef struct {int due; int idx; int bank; int data;} ret_t;
  ret_t rq[$];
  int m_left, m_word, m_base, m_bank, m_last_due, m_cnt;
  bit m_drain, m_underrun;
  bit e_rd, e_wr;
  int e_addr, e_wdata;

  // Stimulus state
  int hp = 0, vp = 0, line_len = 12;
  bit rand_mode = 0;
  bit hv = 0;
  int ha = 0, hd = 0;
  int host_pct = 0, clr_pct = 0;

  task automatic model_clear();
    rq.delete();
    m_left = 0; m_word = 0; m_base = 0; m_bank = 0; m_last_due = 0; m_cnt = 0;
    m_drain = 0; m_underrun = 0; e_rd = 0; e_wr = 0; e_addr = 0; e_wdata = 0;
  endtask

  task automatic cycle(input bit rst);
    bit clr, busy, fetching, hw, gf, gh, exp_we;
    int t;
    clr = ($urandom_range(99) < clr_pct);
    @(posedge pixel_clk);
    #1;
    reset = rst; hpos = 15'(hp); vpos = 15'(vp);
    host_valid = hv; host_addr = ADDR_W'(ha); host_data = 16'(hd);
    underrun_clr = clr;
    @(negedge pixel_clk);
    if (rst) begin
      check_eq("rst_mem_rd", mem_rd, 0);
      check_eq("rst_mem_wr", mem_wr, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_mem_wdata", mem_wdata, 0);
      check_eq("rst_lb_we", lb_we, 0);
      check_eq("rst_lb_bank", lb_bank, 0);
      check_eq("rst_lb_addr", lb_addr, 0);
      check_eq("rst_lb_wdata", lb_wdata, 0);
      check_eq("rst_underrun", underrun, 0);
      check_eq("rst_host_ready", host_ready, 0);
      model_clear();
      cyc++;
      return;
    end
    busy     = (m_left > 0) || (m_drain && m_last_due >= cyc);
    fetching = (m_left > 0);
    hw       = hv && (m_cnt >= BURST);
    gf       = fetching && !hw;
    gh       = hv && (!fetching || hw);

    check_eq("host_ready", host_ready, gh);
    check_eq("mem_rd", mem_rd, e_rd);
    check_eq("mem_wr", mem_wr, e_wr);
    if (e_rd || e_wr) check_eq("mem_addr", mem_addr, e_addr);
    if (e_wr) check_eq("mem_wdata", mem_wdata, e_wdata);
    exp_we = (rq.size() > 0) && (rq[0].due == cyc);
    check_eq("lb_we", lb_we, exp_we);
    if (exp_we) begin
      check_eq("lb_bank", lb_bank, rq[0].bank);
      check_eq("lb_addr", lb_addr, rq[0].idx);
      check_eq("lb_wdata", lb_wdata, rq[0].data);
      void'(rq.pop_front());
    end
    check_eq("underrun", underrun, m_underrun);
    check_eq("scan_bank", scan_bank, vp & 1);

    e_rd = gf;
    e_wr = gh;
    if (gf) begin
      e_addr = (m_base + m_word) & AMASK;
      rq.push_back('{cyc + 1 + RD_LAT, m_word, m_bank, e_addr & 16'hffff});
      m_word++;
      m_left--;
      if (m_left == 0) begin
        m_drain = 1;
        m_last_due = cyc + 1 + RD_LAT;
      end
    end else if (gh) begin
      e_addr = ha;
      e_wdata = hd;
    end
    if (gh || !hv) m_cnt = 0;
    else if (gf) m_cnt++;

    if (hp == 0) begin
      if (vp + 1 < V_ACTIVE) t = vp + 1;
      else if (vp == V_TOTAL - 1) t = 0;
      else t = -1;
      m_drain = 0;
      if (t >= 0) begin
        m_left = H_ACTIVE; m_word = 0; m_bank = t % 2; m_base = t * H_ACTIVE;
      end else begin
        m_left = 0;
      end
    end
    if (hp == 0 && busy) m_underrun = 1;
    else if (clr) m_underrun = 0;

    if (gh) hv = 0;
    if (!hv && ($urandom_range(99) < host_pct)) begin
      hv = 1;
      ha = int'($urandom_range(AMASK));
      hd = int'($urandom_range(16'hffff));
    end
    if (hp >= line_len - 1) begin
      hp = 0;
      vp = (vp == V_TOTAL - 1) ? 0 : vp + 1;
      if (rand_mode) begin
        line_len = int'($urandom_range(16, 7));
        host_pct = int'($urandom_range(100));
      end
    end else begin
      hp++;
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    hv = 0;
    repeat (n) cycle(1'b1);
    hp = 0;
    vp = 0;
  endtask

  task automatic run(input int n);
    repeat (n) cycle(1'b0);
  endtask

  initial begin
    model_clear();
    // Fetch sequence, frame wrap and idle blank lines with no host traffic.
    do_reset(3);
    run(V_TOTAL * 12 + 12);
    // Host traffic mixed into fetch and blanking.
    host_pct = 40;
    run(V_TOTAL * 12);
    // Reset in the middle of a fetch, then a clean restart.
    host_pct = 0;
    for (int i = 0; i < 200 && !(vp == 1 && hp == 4); i++) cycle(1'b0);
    do_reset(2);
    run(V_TOTAL * 12);
    // Host held valid through fetches.
    host_pct = 100;
    run(2 * V_TOTAL * 12);
    // Short lines starve the fetch; clear held across line starts loses to set.
    line_len = 6;
    run(18);
    clr_pct = 100;
    run(12);
    clr_pct = 0;
    line_len = 12;
    host_pct = 0;
    run(V_TOTAL * 12);
    clr_pct = 100;
    run(3);
    clr_pct = 0;
    run(6);
    // Randomized line lengths, host load and flag clears.
    rand_mode = 1;
    clr_pct = 3;
    run(3000);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
